ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Shares the single external SRAM between the screen fetch engine and the CPU bus interface.
- Divides time into 14 MHz slots of two clk28 cycles and assigns each slot to VIDEO, CPU or IDLE.
- Drives the SRAM address, data and strobes, and returns read data to the owner of each slot.
- Generates fetch_allow for the screen controller; this guarantees CPU forward progress during continuous video or ULAplus fetching.

Parameters:
- RAM_AW, 19, SRAM address width (512 KiB).
- MAX_WAIT, 4, maximum slots a pending CPU request may lose to video before video is throttled; legal range 1..15.

Ports:
- clk28  in  1  master clock
- rst_n  in  1  reset, asynchronous, active-low
- ck14  in  1  slot strobe, high on the clk28 cycle ending each slot (one cycle in two)
- video_want  in  1  screen intends to fetch this slot (loading | up_en)
- video_addr  in  15  screen byte address inside the screen page
- screen_page  in  1  0 = page 5, 1 = page 7
- fetch_allow  out  1  video may take the next slot
- video_data  out  8  read data to the screen, sampled by it at ck14
- cpu_req  in  1  one-cycle request pulse
- cpu_we  in  1  1 = write, 0 = read; qualified by cpu_req
- cpu_addr  in  RAM_AW  physical CPU address
- cpu_wdata  in  8  write data
- cpu_busy  out  1  request pending
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  read data, valid from cpu_ack onward
- ram_a  out  RAM_AW  SRAM address
- ram_dq_o  out  8  SRAM write data
- ram_dq_oe  out  1  SRAM data bus drive enable
- ram_dq_i  in  8  SRAM read data
- ram_oe_n  out  1  SRAM output enable, active-low
- ram_we_n  out  1  SRAM write enable, active-low

Behaviour:
- Reset values:
  - owner = IDLE, cpu_busy = 0, cpu_ack = 0, cpu_rdata = 0, wait_cnt = 0.
  - ram_oe_n = 1, ram_we_n = 1, ram_dq_oe = 0, ram_a = 0, ram_dq_o = 0, fetch_allow = 1.
- Request capture:
  - On cpu_req while !cpu_busy: latch cpu_we, cpu_addr and cpu_wdata; cpu_busy = 1 next cycle.
  - cpu_req while cpu_busy is ignored; the caller must not issue it.
  - A request captured on a ck14 edge is not eligible until the following ck14.
- Arbitration at each ck14 edge (a slot decision):
  - owner <= VIDEO if video_want && fetch_allow.
  - Otherwise owner <= CPU if cpu_busy.
  - Otherwise owner <= IDLE.
- fetch_allow = !(cpu_busy && wait_cnt >= MAX_WAIT), combinational from registers.
- wait_cnt:
  - At ck14: +1 (saturating at 15) if cpu_busy and owner goes VIDEO.
  - Cleared when owner goes CPU, or when !cpu_busy.
- Slot phases: phase A is the clk28 cycle after the ck14 edge; phase B is the next cycle. ram_a and strobes are registered.
- VIDEO slot:
  - ram_a = {zero-extend, 1, screen_page, 1, video_addr[13:0]}.
  - ram_oe_n = 0 in A and B.
  - video_data = ram_dq_i, passed through combinationally.
- CPU read slot:
  - ram_a = latched address; ram_oe_n = 0 in A and B.
  - At the closing ck14: cpu_rdata <= ram_dq_i, cpu_ack = 1 for one cycle, cpu_busy = 0.
- CPU write slot:
  - ram_dq_oe = 1 and ram_dq_o = wdata in A and B.
  - ram_oe_n = 1 throughout; ram_we_n = 0 in B only.
  - At the closing ck14: cpu_ack pulse, cpu_busy = 0.
- IDLE slot: all strobes inactive, ram_dq_oe = 0, ram_a holds its last value.
- Latency: an uncontended CPU access acks 2 ck14 edges after capture. The worst-case wait is MAX_WAIT+1 slots beyond that.
- Back-to-back: a new request may be captured on the cycle after cpu_ack; it becomes eligible at the next ck14.
- Reset asserted mid-write: ram_we_n and ram_dq_oe deassert immediately; any pending request is discarded with no ack.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- Defined: wait_cnt and fetch_allow throttling operate as described above.
- Undefined: wait_cnt is removed and fetch_allow is tied to 1. Video has absolute priority, and the CPU is served only in slots where video_want = 0.

Test Plan:
1. Reset, then ck14 running with video_want = 0; cpu_req read at addr 0x14000 with SRAM model holding 0x5A there -> ram_oe_n low for one slot at 0x14000; cpu_ack 2 ck14 later; cpu_rdata = 0x5A.
2. CPU write 0xA5 to 0x00123 -> ram_we_n low exactly 1 clk28 (phase B), ram_dq_oe high 2 cycles, ram_oe_n stays 1; readback returns 0xA5.
3. video_want = 1 continuously, screen_page = 1, video_addr = 0x1800 -> ram_a = 0x1D800 every slot; video_data tracks ram_dq_i.
4. Guard on, MAX_WAIT = 4, video_want = 1 held, CPU read issued -> fetch_allow low for exactly one slot after 4 video slots; cpu_ack follows; fetch_allow returns to 1.
5. Guard off, same stimulus -> cpu_busy stays 1 until video_want drops, then ack within 2 slots.
6. Assert rst_n during a write slot in phase B -> ram_we_n = 1 and cpu_busy = 0 asynchronously; no cpu_ack after release.

Source files
------------

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - SRAM slot arbiter between screen fetch and CPU; optional starvation guard via ARB_STARVE_GUARD_EN
module ram_arbiter #(
    parameter int RAM_AW   = 19,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk28,
    input  logic              rst_n,
    input  logic              ck14,
    input  logic              video_want,
    input  logic [14:0]       video_addr,
    input  logic              screen_page,
    output logic              fetch_allow,
    output logic [7:0]        video_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [RAM_AW-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    output logic [RAM_AW-1:0] ram_a,
    output logic [7:0]        ram_dq_o,
    output logic              ram_dq_oe,
    input  logic [7:0]        ram_dq_i,
    output logic              ram_oe_n,
    output logic              ram_we_n
);

    typedef enum logic [1:0] {
        OWN_IDLE  = 2'd0,
        OWN_VIDEO = 2'd1,
        OWN_CPU   = 2'd2
    } owner_t;

    owner_t            owner;
    logic              lat_we;
    logic [RAM_AW-1:0] lat_addr;
    logic [7:0]        lat_wdata;
    logic              cpu_pending;
    logic              video_go;
    logic [RAM_AW-1:0] video_ram_a;
    logic              unused_addr_msb;

    // A request is competing for a slot only while it is not already being served
    assign cpu_pending = cpu_busy && (owner != OWN_CPU);
    assign video_go    = video_want && fetch_allow;

    // Screen pages 5 and 7 live at 0x14000 / 0x1C000; bit 14 of the screen address is not used
    assign video_ram_a     = RAM_AW'({1'b1, screen_page, 1'b1, video_addr[13:0]});
    assign unused_addr_msb = video_addr[14];

    // Read data goes straight to the screen, which samples it at the closing ck14
    assign video_data = ram_dq_i;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;

    assign fetch_allow = !(cpu_busy && (wait_cnt >= WAIT_LIMIT));

    // Count slots a pending CPU request has lost to video; saturates at 15
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 4'd0;
        end else if (!cpu_busy) begin
            wait_cnt <= 4'd0;
        end else if (ck14 && cpu_pending) begin
            if (!video_go) begin
                wait_cnt <= 4'd0;
            end else if (wait_cnt != 4'hF) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end
`else
    localparam int unused_max_wait = MAX_WAIT;

    assign fetch_allow = 1'b1;
`endif

    // Request capture, slot decision at ck14, registered SRAM strobes and CPU completion
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= OWN_IDLE;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= 8'd0;
            cpu_busy  <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= 8'd0;
            ram_a     <= '0;
            ram_dq_o  <= 8'd0;
            ram_dq_oe <= 1'b0;
            ram_oe_n  <= 1'b1;
            ram_we_n  <= 1'b1;
        end else begin
            cpu_ack <= 1'b0;
            if (cpu_req && !cpu_busy) begin
                lat_we    <= cpu_we;
                lat_addr  <= cpu_addr;
                lat_wdata <= cpu_wdata;
                cpu_busy  <= 1'b1;
            end
            if (ck14) begin
                if (owner == OWN_CPU) begin
                    cpu_busy <= 1'b0;
                    cpu_ack  <= 1'b1;
                    if (!lat_we) begin
                        cpu_rdata <= ram_dq_i;
                    end
                end
                ram_we_n <= 1'b1;
                if (video_go) begin
                    owner     <= OWN_VIDEO;
                    ram_a     <= video_ram_a;
                    ram_oe_n  <= 1'b0;
                    ram_dq_oe <= 1'b0;
                end else if (cpu_pending) begin
                    owner     <= OWN_CPU;
                    ram_a     <= lat_addr;
                    ram_oe_n  <= lat_we;
                    ram_dq_oe <= lat_we;
                    if (lat_we) begin
                        ram_dq_o <= lat_wdata;
                    end
                end else begin
                    owner     <= OWN_IDLE;
                    ram_oe_n  <= 1'b1;
                    ram_dq_oe <= 1'b0;
                end
            end else if (owner == OWN_CPU && lat_we) begin
                ram_we_n <= 1'b0;
            end
        end
    end

endmodule
